// File: rtl/dbgnoc_pkg.sv
// Shared debug NoC definitions: flit types, register map,
// clog2 helper and FSM state encodings.
package dbgnoc_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    localparam logic [4:0] REG_DATA   = 5'h00;
    localparam logic [4:0] REG_AVAIL  = 5'h10;
    localparam logic [4:0] REG_STATUS = 5'h14;
    localparam logic [4:0] REG_PKTS   = 5'h18;
    localparam logic [4:0] REG_CTRL   = 5'h1C;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic { RX_IDLE, RX_BODY } rx_state_t;
    typedef enum logic { RD_IDLE, RD_DATA } rd_state_t;

endpackage

// File: rtl/dbgnoc_na_input_if.sv
// NoC flit input and bus slave signals of the receive adapter.
// master drives flits and bus accesses, slave is the adapter.
interface dbgnoc_na_input_if #(
    parameter int NOC_DATA_WIDTH = 32,
    parameter int NOC_TYPE_WIDTH = 2,
    parameter int ADDRESS_WIDTH  = 32
);
    logic [NOC_DATA_WIDTH+NOC_TYPE_WIDTH-1:0] noc_in_flit;
    logic                                     noc_in_valid;
    logic                                     noc_in_ready;
    logic [ADDRESS_WIDTH-1:0]                 bus_addr;
    logic                                     bus_we;
    logic                                     bus_en;
    logic [NOC_DATA_WIDTH-1:0]                bus_data_in;
    logic [NOC_DATA_WIDTH-1:0]                bus_data_out;
    logic                                     bus_ack;

    modport master (
        output noc_in_flit, noc_in_valid, bus_addr, bus_we,
        output bus_en, bus_data_in,
        input  noc_in_ready, bus_data_out, bus_ack
    );

    modport slave (
        input  noc_in_flit, noc_in_valid, bus_addr, bus_we,
        input  bus_en, bus_data_in,
        output noc_in_ready, bus_data_out, bus_ack
    );
endinterface

// File: rtl/dbgnoc_fifo.sv
// Synchronous first-word-fall-through FIFO with full,
// empty and fill level; pushes when full and pops when empty are dropped.
module dbgnoc_fifo
    import dbgnoc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int LW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            cnt <= cnt + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/dbgnoc_na_input.sv
// Receive-side debug NoC adapter: buffers packets, bus reads length then payload.
// Optional irq output with DBGNOC_NA_INPUT_IRQ_EN.
module dbgnoc_na_input
    import dbgnoc_pkg::*;
#(
    parameter int NOC_DATA_WIDTH = 32,
    parameter int NOC_TYPE_WIDTH = 2,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef DBGNOC_NA_INPUT_IRQ_EN
    output logic irq,
`endif
    dbgnoc_na_input_if.slave bus
);
    localparam int CW = clog2(FIFO_DEPTH + 1);

    rx_state_t rx_state, rx_next;
    rd_state_t rd_state, rd_next;

    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [CW-1:0] rd_left, rd_left_next;
    logic [CW-1:0] pkt_cnt, pkt_cnt_next;
    logic          err, err_next;
    logic          live;

    logic [1:0]                ftype;
    logic [NOC_DATA_WIDTH-1:0] fdata;
    logic [2:0]                sel;
    logic                      accept, rd, wr;
    logic                      head_like, in_body;
    logic                      complete, done;
    logic [NOC_DATA_WIDTH-1:0] rdata;

    logic                      data_push, data_pop;
    logic                      data_full, data_empty;
    logic [NOC_DATA_WIDTH-1:0] data_head;
    logic [CW-1:0]             data_level;
    logic                      size_pop;
    logic                      size_full, size_empty;
    logic [CW-1:0]             size_head;
    logic [CW-1:0]             size_level;

    assign ftype     = bus.noc_in_flit[NOC_DATA_WIDTH +: 2];
    assign fdata     = bus.noc_in_flit[NOC_DATA_WIDTH-1:0];
    assign sel       = bus.bus_addr[4:2];
    assign rd        = bus.bus_en && !bus.bus_we;
    assign wr        = bus.bus_en && bus.bus_we;
    assign accept    = bus.noc_in_valid && bus.noc_in_ready;
    assign head_like = (ftype == FLIT_HEADER) || (ftype == FLIT_SINGLE);
    assign in_body   = (rx_state == RX_BODY);

    // Ready is held low until the first clock after reset release
    assign bus.noc_in_ready = live && !data_full && !size_full;
    assign bus.bus_ack      = bus.bus_en;
    assign bus.bus_data_out = rdata;

    dbgnoc_fifo #(.WIDTH(NOC_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_data (
        .clk(clk), .rst(rst),
        .push(data_push), .din(fdata), .pop(data_pop),
        .dout(data_head), .full(data_full), .empty(data_empty),
        .level(data_level)
    );

    dbgnoc_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_size (
        .clk(clk), .rst(rst),
        .push(complete), .din(rx_cnt + CW'(1)), .pop(size_pop),
        .dout(size_head), .full(size_full), .empty(size_empty),
        .level(size_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rd_state <= RD_IDLE;
            rx_cnt   <= '0;
            rd_left  <= '0;
            pkt_cnt  <= '0;
            err      <= 1'b0;
            live     <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rd_state <= rd_next;
            rx_cnt   <= rx_cnt_next;
            rd_left  <= rd_left_next;
            pkt_cnt  <= pkt_cnt_next;
            err      <= err_next;
            live     <= 1'b1;
        end
    end

    always_comb begin
        rx_next      = rx_state;
        rx_cnt_next  = rx_cnt;
        err_next     = err;
        data_push    = 1'b0;
        complete     = 1'b0;
        if (wr && sel == REG_CTRL[4:2] && bus.bus_data_in[0])
            err_next = 1'b0;
        // A header mid-packet keeps the count so the truncated flits stay owned
        if (accept) begin
            if (head_like == in_body) err_next = 1'b1;
            if (head_like || in_body) begin
                data_push   = 1'b1;
                rx_cnt_next = rx_cnt + CW'(1);
                rx_next     = RX_BODY;
                if (ftype == FLIT_SINGLE || ftype == FLIT_LAST) begin
                    complete    = 1'b1;
                    rx_cnt_next = '0;
                    rx_next     = RX_IDLE;
                end
            end
        end
    end

    always_comb begin
        rd_next      = rd_state;
        rd_left_next = rd_left;
        data_pop     = 1'b0;
        size_pop     = 1'b0;
        done         = 1'b0;
        rdata        = '0;
        if (rd) begin
            unique case (1'b1)
                sel == REG_DATA[4:2]: begin
                    if (rd_state == RD_IDLE) begin
                        if (pkt_cnt != '0 && !size_empty) begin
                            rdata        = NOC_DATA_WIDTH'(size_head);
                            size_pop     = 1'b1;
                            rd_left_next = size_head;
                            rd_next      = RD_DATA;
                        end
                    end else begin
                        rdata        = data_head;
                        data_pop     = !data_empty;
                        rd_left_next = rd_left - CW'(1);
                        if (rd_left == CW'(1)) begin
                            rd_next = RD_IDLE;
                            done    = 1'b1;
                        end
                    end
                end
                sel == REG_AVAIL[4:2]:
                    rdata = NOC_DATA_WIDTH'(pkt_cnt != '0);
                sel == REG_STATUS[4:2]:
                    rdata = NOC_DATA_WIDTH'({err, rx_state, rd_state});
                sel == REG_PKTS[4:2]:
                    rdata = NOC_DATA_WIDTH'(pkt_cnt);
                sel == REG_CTRL[4:2]:
                    rdata = NOC_DATA_WIDTH'(data_level);
                default: rdata = '0;
            endcase
        end
        pkt_cnt_next = pkt_cnt + CW'(complete) - CW'(done);
    end

`ifdef DBGNOC_NA_INPUT_IRQ_EN
    logic mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (wr && sel == REG_CTRL[4:2]) mask <= bus.bus_data_in[1];
            irq <= (pkt_cnt != '0 || err) && !mask;
        end
    end
`endif
endmodule

// File: tb/tb_dbgnoc_na_input.sv
// Randomized + directed bench; reads are checked by a negedge monitor
// against a queue filled from a packet-level reference model.
module tb_dbgnoc_na_input;
    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef DBGNOC_NA_INPUT_IRQ_EN
    logic irq;
`endif

    dbgnoc_na_input_if #(.NOC_DATA_WIDTH(32), .NOC_TYPE_WIDTH(2), .ADDRESS_WIDTH(32)) bus_if ();

    dbgnoc_na_input dut (
        .clk(clk),
        .rst(rst),
`ifdef DBGNOC_NA_INPUT_IRQ_EN
        .irq(irq),
`endif
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: contents of buffers and counters as the spec describes them
    int unsigned dq[$];
    int unsigned sq[$];
    int unsigned expq[$];
    int partial = 0;
    bit in_body = 0;
    bit err = 0;
    int pkts = 0;
    int left = 0;
    bit reading = 0;
    bit live = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        dq.delete();
        sq.delete();
        partial = 0;
        in_body = 0;
        err = 0;
        pkts = 0;
        left = 0;
        reading = 0;
        live = 0;
    endtask

    function automatic bit model_ready();
        return live && dq.size() < 16 && sq.size() < 16;
    endfunction

    task automatic model_flit(input logic [1:0] t, input int unsigned d);
        case (t)
            2'b01: begin
                if (in_body) err = 1;
                dq.push_back(d);
                partial++;
                in_body = 1;
            end
            2'b11: begin
                if (in_body) err = 1;
                dq.push_back(d);
                sq.push_back(partial + 1);
                partial = 0;
                pkts++;
                in_body = 0;
            end
            2'b00: begin
                if (in_body) begin
                    dq.push_back(d);
                    partial++;
                end else err = 1;
            end
            default: begin
                if (in_body) begin
                    dq.push_back(d);
                    sq.push_back(partial + 1);
                    partial = 0;
                    pkts++;
                    in_body = 0;
                end else err = 1;
            end
        endcase
    endtask

    function automatic int unsigned model_read(input logic [4:0] a);
        int unsigned v;
        v = 0;
        case (a[4:2])
            3'd0: begin
                if (reading) begin
                    v = dq.pop_front();
                    left--;
                    if (left == 0) begin
                        reading = 0;
                        pkts--;
                    end
                end else if (pkts > 0) begin
                    v = sq.pop_front();
                    left = int'(v);
                    reading = 1;
                end
            end
            3'd4: v = (pkts != 0) ? 1 : 0;
            3'd5: v = {29'd0, err, in_body, reading};
            3'd6: v = pkts;
            3'd7: v = dq.size();
            default: v = 0;
        endcase
        return v;
    endfunction

    // One clock: drive at posedge+1, model the edge, check ready after it
    task automatic cycle(input bit v, input logic [1:0] t, input int unsigned d,
                         input bit en, input bit we, input logic [4:0] a,
                         input int unsigned wd);
        bit rdy;
        bus_if.noc_in_valid = v;
        bus_if.noc_in_flit  = {t, d};
        bus_if.bus_en       = en;
        bus_if.bus_we       = we;
        bus_if.bus_addr     = {27'd0, a};
        bus_if.bus_data_in  = wd;
        rdy = model_ready();
        if (en && !we) expq.push_back(model_read(a));
        if (en && we && a[4:2] == 3'd7 && wd[0]) err = 0;
        if (v && rdy) model_flit(t, d);
        @(posedge clk);
        live = 1;
        #1;
        check("noc_in_ready", bus_if.noc_in_ready, model_ready());
    endtask

    task automatic flit(input logic [1:0] t, input int unsigned d);
        cycle(1, t, d, 0, 0, 5'h00, 0);
    endtask

    task automatic rd(input logic [4:0] a);
        cycle(0, 2'b00, 0, 1, 0, a, 0);
    endtask

    task automatic wr(input logic [4:0] a, input int unsigned wd);
        cycle(0, 2'b00, 0, 1, 1, a, wd);
    endtask

    task automatic do_reset();
        bus_if.noc_in_valid = 0;
        bus_if.bus_en       = 0;
        bus_if.bus_we       = 0;
        rst = 0;
        model_clear();
        #2;
        check("rst_ready", bus_if.noc_in_ready, 0);
        check("rst_ack", bus_if.bus_ack, 0);
        check("rst_data", bus_if.bus_data_out, 0);
        @(posedge clk);
        #1;
        check("rst_ready_hold", bus_if.noc_in_ready, 0);
        rst = 1;
    endtask

    always @(negedge clk) begin
        int unsigned e;
        nchk++;
        if (bus_if.bus_ack !== bus_if.bus_en) begin
            nerr++;
            $display("FAIL bus_ack: got %0b want %0b", bus_if.bus_ack, bus_if.bus_en);
        end
        if (bus_if.bus_en === 1'b1 && bus_if.bus_we === 1'b0) begin
            if (expq.size() == 0) begin
                nerr++;
                $display("FAIL scoreboard: read seen with no expectation");
            end else begin
                e = expq.pop_front();
                check($sformatf("read_%02h", bus_if.bus_addr[4:0]), bus_if.bus_data_out, e);
            end
        end else begin
            check("idle_data_out", bus_if.bus_data_out, 0);
        end
    end

    initial begin
        bus_if.noc_in_valid = 0;
        bus_if.noc_in_flit  = '0;
        bus_if.bus_en       = 0;
        bus_if.bus_we       = 0;
        bus_if.bus_addr     = '0;
        bus_if.bus_data_in  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", bus_if.noc_in_ready, 0);
        rst = 1;

        // single-flit packet
        flit(2'b11, 32'hA5);
        rd(5'h10); rd(5'h00); rd(5'h00); rd(5'h10);

        // three-flit packet
        flit(2'b01, 1); flit(2'b00, 2); flit(2'b10, 3);
        rd(5'h18);
        repeat (4) rd(5'h00);
        rd(5'h18);

        // fill to capacity, drain one, then the rest
        for (int i = 0; i < 16; i++) flit(2'b11, 32'h100 + i);
        flit(2'b11, 32'hDEAD);
        rd(5'h18); rd(5'h1C);
        rd(5'h00); rd(5'h00);
        rd(5'h18);
        for (int i = 0; i < 30; i++) rd(5'h00);
        rd(5'h10);

        // stray LAST in idle, then clear err
        flit(2'b10, 32'h77);
        rd(5'h14); rd(5'h1C);
        wr(5'h1C, 1);
        rd(5'h14);

        // LAST completes while the previous packet's final word is read
        flit(2'b11, 32'h11);
        flit(2'b01, 32'h20);
        rd(5'h00);
        cycle(1, 2'b10, 32'h21, 1, 0, 5'h00, 0);
        rd(5'h18);
        repeat (3) rd(5'h00);
        rd(5'h18);

        // reset mid-packet
        flit(2'b01, 32'h55);
        do_reset();
        flit(2'b00, 32'h56);
        rd(5'h18); rd(5'h1C); rd(5'h00); rd(5'h14);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit v;
            logic [1:0] t;
            int unsigned r;
            logic [4:0] a;
            v = 1'($urandom);
            t = 2'($urandom);
            if (partial >= 12) t = 2'b10;
            r = $urandom % 8;
            a = 5'($urandom % 8) << 2;
            if (i == 1500) do_reset();
            if (r < 4)
                cycle(v, t, $urandom, 1, 0, 5'h00, 0);
            else if (r == 4)
                cycle(v, t, $urandom, 1, 0, a, 0);
            else if (r == 5 && ($urandom % 4) == 0)
                cycle(v, t, $urandom, 1, 1, a, $urandom % 4);
            else
                cycle(v, t, $urandom, 0, 0, 5'h00, 0);
        end

        bus_if.noc_in_valid = 0;
        bus_if.bus_en       = 0;
        @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
